// File: rtl/hdc_pkg.sv
// hdc_pkg: shared readout FSM states, class tags and the ceil_div sizing helper
package hdc_pkg;
  typedef enum logic [1:0] {IDLE, SEND_NS, SEND_S, DONE} readout_state_t;
  localparam logic TAG_NS = 1'b0;
  localparam logic TAG_S = 1'b1;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/hv_readout_if.sv
// hv_readout_if: word stream (data, valid, ready, tag, last); master drives all but ready
interface hv_readout_if #(parameter int WORD_WIDTH = 32);
  logic [WORD_WIDTH-1:0] data;
  logic valid;
  logic ready;
  logic tag;
  logic last;
  modport master(output data, valid, tag, last, input ready);
  modport slave(input data, valid, tag, last, output ready);
endinterface

// File: rtl/hv_word_sel.sv
// hv_word_sel: combinational pick of word idx from hv (LSB-first), zero-padding bits past DIMENSIONS
module hv_word_sel import hdc_pkg::*; #(
  parameter int DIMENSIONS = 10000,
  parameter int WORD_WIDTH = 32,
  localparam int NUM_WORDS = ceil_div(DIMENSIONS, WORD_WIDTH),
  localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1
) (
  input  logic [DIMENSIONS-1:0] hv,
  input  logic [IDX_W-1:0]      idx,
  output logic [WORD_WIDTH-1:0] word
);
  logic [NUM_WORDS*WORD_WIDTH-1:0] padded;
  always_comb begin
    padded = '0;
    padded[DIMENSIONS-1:0] = hv;
    word = padded[idx*WORD_WIDTH +: WORD_WIDTH];
  end
endmodule

// File: rtl/hv_readout.sv
// hv_readout: snapshots ns_hv/s_hv on start and streams them as tagged words (clk, nrst, start, ns_hv, s_hv in; out stream, busy, done out)
module hv_readout import hdc_pkg::*; #(
  parameter int DIMENSIONS = 10000,
  parameter int WORD_WIDTH = 32,
  localparam int NUM_WORDS = ceil_div(DIMENSIONS, WORD_WIDTH),
  localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [DIMENSIONS-1:0] ns_hv,
  input  logic [DIMENSIONS-1:0] s_hv,
  hv_readout_if.master          out,
  output logic                  busy,
  output logic                  done
);
  readout_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIMENSIONS-1:0] shadow_ns_q, shadow_ns_d, shadow_s_q, shadow_s_d;
  logic [WORD_WIDTH-1:0] word;
  logic hs, at_end, accept;
  hv_word_sel #(.DIMENSIONS(DIMENSIONS), .WORD_WIDTH(WORD_WIDTH)) u_sel (
    .hv(state_q == SEND_S ? shadow_s_q : shadow_ns_q),
    .idx(idx_q),
    .word(word)
  );
  always_comb begin
    out.valid = state_q == SEND_NS || state_q == SEND_S;
    at_end = idx_q == IDX_W'(NUM_WORDS - 1);
    out.data = out.valid ? word : '0;
    out.tag = state_q == SEND_S ? TAG_S : TAG_NS;
    out.last = state_q == SEND_S && at_end;
    busy = out.valid;
    done = state_q == DONE;
    hs = out.valid && out.ready;
    accept = state_q == IDLE && start;
    idx_d = accept || (hs && at_end) ? '0 : hs ? idx_q + 1'b1 : idx_q;
    shadow_ns_d = accept ? ns_hv : shadow_ns_q;
    shadow_s_d = accept ? s_hv : shadow_s_q;
    state_d = state_q == IDLE ? (start ? SEND_NS : IDLE) :
              state_q == SEND_NS ? (hs && at_end ? SEND_S : SEND_NS) :
              state_q == SEND_S ? (hs && at_end ? DONE : SEND_S) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q <= '0;
      shadow_ns_q <= '0;
      shadow_s_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shadow_ns_q <= shadow_ns_d;
      shadow_s_q <= shadow_s_d;
    end
  end
endmodule

// File: tb/tb_hv_readout.sv
// tb_hv_readout: scoreboard bench for hv_readout in a 70-bit config and the 10000-bit default
module tb_hv_readout;
  typedef struct packed {logic [31:0] d; logic t; logic l;} ent_t;
  logic clk = 0, nrst = 0, start = 0, start2 = 0;
  always #5 clk = ~clk;
  logic [69:0] ns_hv, s_hv, ns_pat;
  logic busy, done, busy2, done2;
  logic [9999:0] ns2, s2;
  hv_readout_if #(.WORD_WIDTH(32)) sif();
  hv_readout_if #(.WORD_WIDTH(32)) bif();
  hv_readout #(.DIMENSIONS(70), .WORD_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .start(start), .ns_hv(ns_hv), .s_hv(s_hv),
    .out(sif), .busy(busy), .done(done));
  hv_readout #(.DIMENSIONS(10000), .WORD_WIDTH(32)) dut2 (
    .clk(clk), .nrst(nrst), .start(start2), .ns_hv(ns2), .s_hv(s2),
    .out(bif), .busy(busy2), .done(done2));
  int n_cmp = 0, n_fail = 0;
  ent_t exp_q[$];
  logic [31:0] exp_w [6] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0000002A,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000003F};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // small-config monitor: scoreboard pop, stall stability, done timing
  logic [31:0] h_d;
  logic h_t, h_l, held = 0, pend = 0;
  int hs_cnt = 0, done_cnt = 0;
  ent_t e;
  always @(negedge clk) begin
    if (done || pend) chk("done_pulse", 64'(done), 64'(pend));
    if (done) done_cnt++;
    pend = sif.valid && sif.ready && sif.last;
    if (sif.valid && held) chk("stall_hold", 64'({sif.data, sif.tag, sif.last}), 64'({h_d, h_t, h_l}));
    if (sif.valid && sif.ready) begin
      hs_cnt++;
      held = 0;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got %h with no word expected", sif.data);
      end else begin
        e = exp_q.pop_front();
        chk("word", 64'({sif.data, sif.tag, sif.last}), 64'({e.d, e.t, e.l}));
      end
    end else begin
      held = sif.valid;
      h_d = sif.data;
      h_t = sif.tag;
      h_l = sif.last;
    end
  end
  // default-config monitor: reassemble both HVs by tag
  logic [313*32-1:0] rb_ns = '1, rb_s = '1;
  int bh = 0, b2done = 0;
  always @(negedge clk) begin
    if (done2) b2done++;
    if (bif.valid && bif.ready) begin
      if (bh < 626) begin
        chk("big_tag", 64'(bif.tag), 64'(bh >= 313));
        chk("big_last", 64'(bif.last), 64'(bh == 625));
        if (bh < 313) rb_ns[bh*32 +: 32] = bif.data;
        else rb_s[(bh-313)*32 +: 32] = bif.data;
      end
      bh++;
    end
  end
  // mode: 0 plain, 1 backpressure, 2 snapshot, 3 start while busy, 4 reset at word 4
  task automatic xfer(input int mode);
    int d0, h0, cyc;
    logic pulsed;
    d0 = done_cnt;
    h0 = hs_cnt;
    cyc = 0;
    pulsed = 0;
    ns_hv = ns_pat;
    s_hv = '1;
    for (int k = 0; k < 6; k++) exp_q.push_back(ent_t'{exp_w[k], k > 2, k == 5});
    @(posedge clk); #1 start = 1; sif.ready = 1;
    @(posedge clk); #1 start = 0;
    if (mode == 2) begin ns_hv = '0; s_hv = '0; end
    @(negedge clk);
    chk("valid_latency", 64'(sif.valid), 64'(1));
    chk("busy_on", 64'(busy), 64'(1));
    while (done_cnt == d0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      sif.ready = mode == 1 ? cyc % 3 == 0 : 1'b1;
      start = mode == 3 && hs_cnt - h0 == 2 && !pulsed;
      if (start) pulsed = 1;
      if (mode == 4 && hs_cnt - h0 == 4) begin
        nrst = 0;
        @(posedge clk); #1 nrst = 1;
        @(negedge clk);
        chk("abort_valid", 64'(sif.valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        exp_q.delete();
        repeat (4) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        return;
      end
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: no done within %0d cycles (mode %0d)", cyc, mode);
    end
    chk("handshakes", 64'(hs_cnt - h0), 64'(6));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (4) @(negedge clk);
    chk("idle_after", 64'(busy), 64'(0));
    chk("single_done", 64'(done_cnt - d0), 64'(1));
  endtask
  initial begin
    logic [10015:0] t1, t2;
    int cyc;
    for (int i = 0; i < 70; i++) ns_pat[i] = i % 2 == 1;
    ns_hv = ns_pat;
    s_hv = '1;
    sif.ready = 0;
    bif.ready = 0;
    ns2 = '0;
    s2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(sif.valid), 64'(0));
    chk("rst_data", 64'(sif.data), 64'(0));
    chk("rst_tag", 64'(sif.tag), 64'(0));
    chk("rst_last", 64'(sif.last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    #1 nrst = 1;
    xfer(0);
    xfer(1);
    xfer(2);
    xfer(3);
    xfer(4);
    xfer(0);
    for (int i = 0; i < 313; i++) begin
      t1[i*32 +: 32] = $urandom;
      t2[i*32 +: 32] = $urandom;
    end
    @(posedge clk); #1;
    ns2 = t1[9999:0];
    s2 = t2[9999:0];
    bif.ready = 1;
    start2 = 1;
    @(posedge clk); #1 start2 = 0;
    cyc = 0;
    while (b2done == 0 && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("big_done", 64'(b2done), 64'(1));
    chk("big_handshakes", 64'(bh), 64'(626));
    chk("big_pad_ns", 64'(rb_ns[10015:10000]), 64'(0));
    chk("big_pad_s", 64'(rb_s[10015:10000]), 64'(0));
    n_cmp++;
    if (rb_ns[9999:0] !== ns2) begin
      n_fail++;
      $display("FAIL big_ns: reassembled low word %h expected %h", rb_ns[31:0], ns2[31:0]);
    end
    n_cmp++;
    if (rb_s[9999:0] !== s2) begin
      n_fail++;
      $display("FAIL big_s: reassembled low word %h expected %h", rb_s[31:0], s2[31:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
